regfile_wb_arbiter: RTL and testbench

Write-back arbiter that owns the single write port of the integer register file, driving its write-enable, write-address and write-data inputs. It merges a single-cycle ALU result stream with a handshaked load/store-unit (LSU) result stream. LSU results are buffered in a small queue and younger ALU writes kill stale queued writes to the same register, so write-after-write order is preserved. It sits between the execute/memory stages and the register file, and exports a pending-destination mask for hazard detection.

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_queue.sv | 83 ++++++++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types, default widths and helpers for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int unsigned WB_N          = 32;
  localparam int unsigned WB_A          = 5;
  localparam int unsigned WB_DEPTH      = 4;
  localparam int unsigned WB_STARVE_MAX = 8;

  typedef struct packed {
    logic [WB_A-1:0] rd;
    logic [WB_N-1:0] data;
    logic            live;
  } wb_entry_t;

  function automatic logic [31:0] onehot32(input logic [WB_A-1:0] rd);
    onehot32 = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_queue.sv
// wb_queue: circular FIFO of pending LSU write-backs with kill-by-rd and a
// registered pending-destination mask reflecting the post-edge queue contents.
module wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic             kill_i,
  input  logic [WB_A-1:0]  kill_rd_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEPTH-1:0] live_mask_o,
  output logic [31:0]      pending_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pending_q, pending_d;
  logic          do_push, do_pop;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pending_o = pending_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) live_mask_o[i] = mem_q[i].live;
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && (mem_q[i].rd == kill_rd_i)) mem_d[i].live = 1'b0;
    end
    // Popped slots are cleared so the pending mask only sees occupied entries.
    if (do_pop) begin
      mem_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_i;
      if (kill_i && (push_entry_i.rd == kill_rd_i)) mem_d[wr_ptr_q].live = 1'b0;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_d[i].live) pending_d = pending_d | onehot32(mem_d[i].rd);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU results win the write port, LSU results queue.
// Optional WB_BYPASS_EN lets an LSU result skip the empty queue straight to the port.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = WB_DEPTH,
  parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  input  logic [WB_A-1:0] alu_rd_i,
  input  logic [WB_N-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [WB_A-1:0] lsu_rd_i,
  input  logic [WB_N-1:0] lsu_data_i,
  output logic            we3_o,
  output logic [WB_A-1:0] addr3_o,
  output logic [WB_N-1:0] wd3_o,
  output logic [31:0]     lsu_pending_o,
  output logic            stall_req_o
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  wb_entry_t        q_head, push_entry;
  logic             q_full, q_empty;
  logic [DEPTH-1:0] q_live_mask;
  logic             alu_win, lsu_fire, bypass, push, pop;
  logic             we_q, we_d;
  logic [WB_A-1:0]  addr_q, addr_d;
  logic [WB_N-1:0]  wd_q, wd_d;
  logic [SW-1:0]    starve_q, starve_d;

  assign lsu_ready_o = !q_full;
  assign alu_win     = alu_valid_i && (alu_rd_i != '0);
  assign lsu_fire    = lsu_valid_i && !q_full;
`ifdef WB_BYPASS_EN
  assign bypass      = lsu_fire && q_empty && !alu_valid_i && (lsu_rd_i != '0);
`else
  assign bypass      = 1'b0;
`endif
  // x0 results are accepted but never stored; any ALU beat (even to x0) holds the port.
  assign push        = lsu_fire && (lsu_rd_i != '0) && !bypass;
  assign pop         = !alu_valid_i && !q_empty;
  assign push_entry  = '{rd: lsu_rd_i, data: lsu_data_i, live: 1'b1};

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (alu_win),
    .kill_rd_i    (alu_rd_i),
    .head_o       (q_head),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .live_mask_o  (q_live_mask),
    .pending_o    (lsu_pending_o)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    wd_d   = wd_q;
    if (alu_win) begin
      we_d   = 1'b1;
      addr_d = alu_rd_i;
      wd_d   = alu_data_i;
    end else if (pop && q_head.live) begin
      we_d   = 1'b1;
      addr_d = q_head.rd;
      wd_d   = q_head.data;
    end else if (bypass) begin
      we_d   = 1'b1;
      addr_d = lsu_rd_i;
      wd_d   = lsu_data_i;
    end
  end

  // Down-counter: reloads whenever nothing live is waiting, terminal count raises stall_req.
  always_comb begin
    starve_d = starve_q;
    if (pop || (q_live_mask == '0)) starve_d = SW'(STARVE_MAX);
    else if (q_head.live && (starve_q != '0)) starve_d = starve_q - 1'b1;
  end

  assign stall_req_o = (starve_q == '0);
  assign we3_o       = we_q;
  assign addr3_o     = addr_q;
  assign wd3_o       = wd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      starve_q <= SW'(STARVE_MAX);
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; honours WB_BYPASS_EN for bypass latency.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        we3;
  logic [4:0]  addr3;
  logic [31:0] wd3;
  logic [31:0] lsu_pending;
  logic        stall_req;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_alu = 0;

  regfile_wb_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_rd_i      (lsu_rd),
    .lsu_data_i    (lsu_data),
    .we3_o         (we3),
    .addr3_o       (addr3),
    .wd3_o         (wd3),
    .lsu_pending_o (lsu_pending),
    .stall_req_o   (stall_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ALU traffic while stall_req is high is legal but flagged.
  always @(negedge clk) if (rst_n && stall_req && alu_valid) stall_alu++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && we3) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", addr3, wd3);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", 32'(addr3), 32'(e.addr));
        check("wb_data", wd3, e.data);
        if (e.cyc >= 0) check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (3) tick();
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_ready", 32'(lsu_ready), 32'd1);
    check("rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("idle_we3", 32'(we3), 32'd0);
      check("idle_ready", 32'(lsu_ready), 32'd1);
      check("idle_pending", lsu_pending, 32'd0);
      tick();
    end
    check("idle_addr3", 32'(addr3), 32'd0);
    check("idle_wd3", wd3, 32'd0);

    // ALU write and ALU write to x0
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    exp_wr(5'd5, 32'hDEADBEEF, cyc + 1);
    tick();
    check("alu_we3", 32'(we3), 32'd1);
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    tick();
    check("alu_x0_we3", 32'(we3), 32'd0);
    idle();
    tick();

    // Fill the queue while the ALU holds the port
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(lsu_ready), 32'd1);
      drive(1'b1, 5'd9, 32'h900 + 32'(i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
      exp_wr(5'd9, 32'h900 + 32'(i), cyc + 1);
      tick();
    end
    check("full_ready", 32'(lsu_ready), 32'd0);
    check("full_pending", lsu_pending, 32'h1E);
    for (int i = 0; i < 4; i++) exp_wr(5'(i + 1), 32'h100 + 32'(i), -1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    tick();
    check("after_pop_ready", 32'(lsu_ready), 32'd1);
    check("after_pop_pending", lsu_pending, 32'h1C);
    idle();
    repeat (5) tick();
    check("drained_pending", lsu_pending, 32'd0);

    // Kill: younger ALU write to x7 makes the queued x7 entry dead
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd7, 32'h11);
    exp_wr(5'd10, 32'hA0, cyc + 1);
    tick();
    check("kill_pending_set", lsu_pending, 32'h80);
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
    exp_wr(5'd7, 32'h22, cyc + 1);
    tick();
    check("kill_pending_clr", lsu_pending, 32'd0);
    idle();
    tick();
    check("dead_pop_we3", 32'(we3), 32'd0);
    tick();

    // Starvation
    drive(1'b1, 5'd10, 32'hB0, 1'b1, 5'd6, 32'h66);
    exp_wr(5'd10, 32'hB0, cyc + 1);
    tick();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 5'd11, 32'hC00 + 32'(i), 1'b0, 5'd0, 32'd0);
      exp_wr(5'd11, 32'hC00 + 32'(i), cyc + 1);
      tick();
    end
    check("starve_7", 32'(stall_req), 32'd0);
    drive(1'b1, 5'd11, 32'hC08, 1'b0, 5'd0, 32'd0);
    exp_wr(5'd11, 32'hC08, cyc + 1);
    tick();
    check("starve_8", 32'(stall_req), 32'd1);
    drive(1'b1, 5'd11, 32'hC09, 1'b0, 5'd0, 32'd0);
    exp_wr(5'd11, 32'hC09, cyc + 1);
    tick();
    check("starve_hold", 32'(stall_req), 32'd1);
    idle();
    exp_wr(5'd6, 32'h66, cyc + 1);
    tick();
    check("starve_release", 32'(stall_req), 32'd0);
    check("stall_alu_flagged", 32'(stall_alu != 0), 32'd1);
    tick();

    // LSU latency through empty queue (bypass or not)
    check("pre_bypass_ready", 32'(lsu_ready), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55);
`ifdef WB_BYPASS_EN
    exp_wr(5'd3, 32'h55, cyc + 1);
    tick();
    check("lsu_lat_pending", lsu_pending, 32'd0);
`else
    exp_wr(5'd3, 32'h55, cyc + 2);
    tick();
    check("lsu_lat_pending", lsu_pending, 32'h8);
`endif
    idle();
    repeat (3) tick();

    // Reset with a partly filled queue
    drive(1'b1, 5'd12, 32'hD0, 1'b1, 5'd13, 32'h13);
    exp_wr(5'd12, 32'hD0, cyc + 1);
    tick();
    drive(1'b1, 5'd14, 32'hD1, 1'b1, 5'd15, 32'h15);
    exp_wr(5'd14, 32'hD1, cyc + 1);
    tick();
    check("mid_pending", lsu_pending, 32'hA000);
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_we3", 32'(we3), 32'd0);
    check("mrst_addr3", 32'(addr3), 32'd0);
    check("mrst_wd3", wd3, 32'd0);
    check("mrst_pending", lsu_pending, 32'd0);
    check("mrst_stall", 32'(stall_req), 32'd0);
    check("mrst_ready", 32'(lsu_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_pending", lsu_pending, 32'd0);
    check("post_rst_we3", 32'(we3), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
